// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 bit-select mux: registered one-hot grant plus encoded
// select, released on done, request withdrawal or a hold-time limit.
module mux_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] C,
   output logic       valid,
   output logic       preempt
);

   typedef enum logic {StIdle, StGrant} state_e;

   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

   state_e     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] c_q, c_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] gnt_q, gnt_d;
   logic       valid_q, valid_d;
   logic       preempt_q, preempt_d;

   logic       limit_hit;
   logic       release_now;
   logic [1:0] scan_start;
   logic [2:0] scan_res;
   logic       found;
   logic [1:0] winner;

   // Returns {found, index} of the first set bit at or after start, wrapping 3 -> 0.
   function automatic logic [2:0] rr_scan(input logic [3:0] r, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign limit_hit   = (hold_q == HoldLast);
   assign release_now = done | ~req[owner_q] | limit_hit;

   // On release the search starts just past the owner, so the old owner is considered last.
   assign scan_start = (state_q == StGrant) ? owner_q + 2'd1 : ptr_q;
   assign scan_res   = rr_scan(req, scan_start);
   assign found      = scan_res[2];
   assign winner     = scan_res[1:0];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      c_d       = c_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      valid_d   = valid_q;
      preempt_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StGrant;
               owner_d = winner;
               gnt_d   = 4'b0001 << winner;
               c_d     = winner;
               valid_d = 1'b1;
               hold_d  = 8'd0;
            end
         end
         StGrant: begin
            if (!release_now) begin
               hold_d = hold_q + 8'd1;
            end else begin
               ptr_d     = owner_q + 2'd1;
               preempt_d = limit_hit & ~done & req[owner_q];
               hold_d    = 8'd0;
               if (found) begin
                  owner_d = winner;
                  gnt_d   = 4'b0001 << winner;
                  c_d     = winner;
               end else begin
                  state_d = StIdle;
                  gnt_d   = 4'b0000;
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         ptr_q     <= 2'd0;
         owner_q   <= 2'd0;
         c_q       <= 2'd0;
         hold_q    <= 8'd0;
         gnt_q     <= 4'b0000;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         c_q       <= c_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt     = gnt_q;
   assign C       = c_q;
   assign valid   = valid_q;
   assign preempt = preempt_q;

endmodule
